beta_lsu: RTL and testbench
===========================

Name: beta_lsu

Overview:
Load/store unit in the Execute stage. It consumes the memory fields of the decode control word (exe_mem_op_en, exe_mem_op, exe_mem_op_size, dec_not_sign_ext) together with the ALU-computed address. It drives a req/gnt/rvalid data-memory handshake, holds the pipeline with a stall while the access is outstanding, and returns aligned, extended load data for register writeback.

Parameters:
ADDR_W, 32, data memory address width
DATA_W, 32, data bus width (fixed 32; byte enables are 4 bits)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
glb_stall_i  in  1  global stall; blocks acceptance of a new access
exe_mem_op_en_i  in  1  memory operation requested
exe_mem_op_i  in  1  0 = load, 1 = store
exe_mem_op_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
dec_not_sign_ext_i  in  1  1 = zero-extend load (LBU/LHU)
addr_i  in  ADDR_W  effective byte address from ALU
wdata_i  in  32  store data (rs2)
rd_addr_i  in  5  load destination register
lsu_stall_o  out  1  holds the pipeline while an access is in flight
lsu_misaligned_o  out  1  one-cycle misaligned/illegal-size flag
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_rvalid_i  in  1  response valid (load data / store ack)
data_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-replicated store data
data_rdata_i  in  32  load data
wb_valid_o  out  1  load result valid, one-cycle pulse
wb_rd_addr_o  out  5  load destination
wb_data_o  out  32  extended load result

Behaviour:
- Clock and reset: single clock clk_i; reset is asynchronous, active-low (rst_ni). On reset, state = IDLE and every registered output = 0. lsu_stall_o is forced to 0 while rst_ni = 0. Reset mid-transaction abandons the access; a later rvalid seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, accept condition: exe_mem_op_en_i & !glb_stall_i & aligned & size != 11.
  - Aligned means: byte always; half needs addr[0] = 0; word needs addr[1:0] = 00.
  - On accept: register addr/we/be/wdata/size/addr[1:0]/not_sign_ext/rd, go to REQ.
- Misaligned case: exe_mem_op_en_i & !glb_stall_i & (misaligned or size = 11) → lsu_misaligned_o = 1 next cycle for exactly one cycle. No request is issued, no stall, state stays IDLE.
- REQ: data_req_o = 1 and address/we/be/wdata held stable until data_gnt_i = 1, then go to WAIT. data_rvalid_i is ignored in REQ (memory returns rvalid no earlier than the cycle after gnt).
- WAIT: data_req_o = 0. On data_rvalid_i go to DONE.
  - Load: capture the extended data and rd into the wb registers.
  - Store: rvalid is the acknowledge only.
- DONE: one cycle. wb_valid_o = 1 for loads only; lsu_stall_o = 0; inputs ignored. Then go to IDLE.
  - This state guarantees the completed instruction, still present on the inputs this cycle, is not re-issued.
- lsu_stall_o (combinational) = (IDLE & accept) | REQ | WAIT.
- Store byte enables and data:
  - byte: be = 1 << addr[1:0], wdata = {4{wdata_i[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata_i[15:0]}}
  - word: be = 1111, wdata = wdata_i
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]
  - half = rdata[16*addr[1] +: 16]
  - word = rdata
  - Sign-extend from the MSB unless not_sign_ext = 1, in which case zero-extend. not_sign_ext is ignored for word.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid on the next cycle): accept at c0, req/gnt at c1, rvalid at c2, wb_valid_o at c3. Stall is high during c0–c2.
- Each extra gnt or rvalid wait cycle extends the stall by one cycle.
- Back-to-back accesses: the next access may be accepted in the IDLE cycle that follows DONE.
- glb_stall_i only gates acceptance in IDLE; an in-flight access always completes.

Test Plan:
- Load word: addr = 0x100, rdata = 0xDEADBEEF, gnt immediate, rvalid next cycle → req at c1 with be = 1111, wb_valid_o at c3, wb_data_o = 0xDEADBEEF, stall high for exactly 3 cycles.
- LB vs LBU: addr = 0x103, rdata = 0x80FF0000 → signed gives 0xFFFFFF80; not_sign_ext = 1 gives 0x00000080.
- SH to addr = 0x22, wdata_i = 0x1234ABCD, gnt delayed 3 cycles → req, addr 0x20, be = 1100 and wdata 0xABCDABCD all held stable for 4 cycles; no wb_valid_o.
- Misaligned LW at addr = 0x102 → lsu_misaligned_o pulses one cycle, data_req_o stays 0, lsu_stall_o stays 0.
- Reset asserted in WAIT, then a stray rvalid after release → outputs at 0 during reset, state IDLE, no wb_valid_o.
- Back-to-back LW then SB, with glb_stall_i = 1 on the cycle the SB first appears → SB accepted only once glb_stall_i drops; LW is written back exactly once.

Source files
------------

// File: rtl/beta_lsu.sv
// Load/store unit: turns the decode memory fields + ALU address into one req/gnt/rvalid data access.
// Latency: accept c0, req/gnt c1, rvalid c2, writeback pulse c3; each gnt/rvalid wait adds one cycle.
// Backpressure: stalls the pipeline from accept until the response; glb_stall_i only gates acceptance.
module beta_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              glb_stall_i,
  input  logic              exe_mem_op_en_i,
  input  logic              exe_mem_op_i,
  input  logic [1:0]        exe_mem_op_size_i,
  input  logic              dec_not_sign_ext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_addr_i,
  output logic              lsu_stall_o,
  output logic              lsu_misaligned_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured access (word address only; the byte offset is kept separately)
  logic [ADDR_W-1:2] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              nse_q;
  logic [4:0]        rd_q;

  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              mis_q;

  logic              size_legal;
  logic              aligned;
  logic              req_ok;
  logic              accept;
  logic              misal;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;
  logic              ld_done;

  // Acceptance decode: legal size and natural alignment for the access width
  always_comb begin
    size_legal = (exe_mem_op_size_i != 2'b11);
    aligned    = 1'b0;
    case (exe_mem_op_size_i)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_i[0];
      2'b10:   aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    req_ok = exe_mem_op_en_i & ~glb_stall_i;
    accept = (state_q == S_IDLE) & req_ok & size_legal & aligned;
    misal  = (state_q == S_IDLE) & req_ok & ~(size_legal & aligned);
  end

  // Store lane placement: byte enables by offset, data replicated across lanes
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = wdata_i;
    case (exe_mem_op_size_i)
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured offset and size
  always_comb begin
    ld_byte = data_rdata_i[7:0];
    case (off_q)
      2'd0:    ld_byte = data_rdata_i[7:0];
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      default: ld_byte = data_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~nse_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~nse_q & ld_half[15]}}, ld_half};
      default: ld_ext = data_rdata_i;
    endcase
    ld_done = (state_q == S_WAIT) & data_rvalid_i & ~we_q;
  end

  // FSM next state; DONE is a one-cycle guard so the completed op is not re-issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ:  if (data_gnt_i) state_d = S_WAIT;
      S_WAIT: if (data_rvalid_i) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Access capture on accept, writeback capture on load response, misalign pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      nse_q      <= 1'b0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= addr_i[ADDR_W-1:2];
        we_q    <= exe_mem_op_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        size_q  <= exe_mem_op_size_i;
        off_q   <= addr_i[1:0];
        nse_q   <= dec_not_sign_ext_i;
        rd_q    <= rd_addr_i;
      end
      wb_valid_q <= ld_done;
      if (ld_done) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= ld_ext;
      end
      mis_q <= misal;
    end
  end

  // Stall covers the accept cycle through the response; never asserted under reset
  assign lsu_stall_o      = rst_ni & (accept | (state_q == S_REQ) | (state_q == S_WAIT));
  assign lsu_misaligned_o = mis_q;
  assign data_req_o       = (state_q == S_REQ);
  assign data_addr_o      = {addr_q, 2'b00};
  assign data_we_o        = we_q;
  assign data_be_o        = be_q;
  assign data_wdata_o     = wdata_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_addr_o     = wb_rd_q;
  assign wb_data_o        = wb_data_q;

endmodule

// File: tb/tb_beta_lsu.sv
// Testbench for beta_lsu: random loads/stores against a lane-level reference model.
// Memory responder applies per-access gnt/rvalid delays; monitors pop expected requests and writebacks.
// Pipeline model holds each op on the inputs until stall and glb_stall are both low.
module tb_beta_lsu;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        glb_stall_i;
  logic        exe_mem_op_en_i;
  logic        exe_mem_op_i;
  logic [1:0]  exe_mem_op_size_i;
  logic        dec_not_sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        lsu_stall_o;
  logic        lsu_misaligned_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;

  beta_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .glb_stall_i(glb_stall_i),
    .exe_mem_op_en_i(exe_mem_op_en_i), .exe_mem_op_i(exe_mem_op_i),
    .exe_mem_op_size_i(exe_mem_op_size_i), .dec_not_sign_ext_i(dec_not_sign_ext_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .lsu_stall_o(lsu_stall_o), .lsu_misaligned_o(lsu_misaligned_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  typedef struct { int g; int r; logic [31:0] rdata; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  wb_t  wb_q[$];

  int checks = 0;
  int failures = 0;
  int mis_exp = 0;
  int mis_seen = 0;
  bit rsp_auto = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: n-byte access at byte offset o within a 4-byte word
  function automatic logic [3:0] ref_be(input int n, input int o);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (i >= o) && (i < o + n);
    return b;
  endfunction

  function automatic logic [31:0] ref_wdata(input int n, input logic [31:0] w);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = w[8*(i % n) +: 8];
    return res;
  endfunction

  function automatic logic [31:0] ref_load(input int n, input int o, input logic nse,
                                           input logic [31:0] rdata);
    longint v;
    longint span;
    span = longint'(1) << (8 * n);
    v = longint'(rdata >> (8 * o)) % span;
    if (!nse && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Memory responder: waits g cycles before gnt, r cycles between gnt and rvalid
  initial begin
    rsp_t d;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rsp_auto && data_req_o) begin
        if (rsp_q.size() == 0) begin
          chk("req_without_access", 32'd1, 32'd0);
        end else begin
          d = rsp_q.pop_front();
          repeat (d.g) begin @(posedge clk); #1; end
          data_gnt_i = 1'b1;
          @(posedge clk); #1;
          data_gnt_i = 1'b0;
          repeat (d.r) begin @(posedge clk); #1; end
          data_rvalid_i = 1'b1;
          data_rdata_i = d.rdata;
          @(posedge clk); #1;
          data_rvalid_i = 1'b0;
          data_rdata_i = $urandom;
        end
      end
    end
  end

  // Request monitor: fields must match and stay stable every REQ cycle; pop on grant
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (data_req_o) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'd1, 32'd0);
        end else begin
          e = req_q[0];
          chk("req_addr", data_addr_o, e.addr);
          chk("req_we", {31'd0, data_we_o}, {31'd0, e.we});
          chk("req_be", {28'd0, data_be_o}, {28'd0, e.be});
          if (e.we) chk("req_wdata", data_wdata_o, e.wdata);
          if (data_gnt_i) void'(req_q.pop_front());
        end
      end
    end
  end

  // Writeback and misalign monitor
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (lsu_misaligned_o) mis_seen++;
      if (wb_valid_o) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          w = wb_q.pop_front();
          chk("wb_rd", {27'd0, wb_rd_addr_o}, {27'd0, w.rd});
          chk("wb_data", wb_data_o, w.data);
        end
      end
    end
  end

  // Present one op and hold it until the pipeline would advance (stall and glb_stall low)
  task automatic run_op(input logic [1:0] size, input logic st, input logic nse,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int g, input int r, input int k, input logic [31:0] rdata);
    int n;
    int o;
    bit legal;
    int stall_cnt;
    int cyc;
    bit adv;
    rsp_t rs;
    req_t rq;
    wb_t  wv;
    n = 1 << size;
    o = int'(addr[1:0]);
    legal = (size != 2'b11) && ((o % n) == 0);
    if (legal) begin
      rs.g = g; rs.r = r; rs.rdata = rdata;
      rsp_q.push_back(rs);
      rq.addr = addr & 32'hFFFF_FFFC; rq.we = st; rq.be = ref_be(n, o); rq.wdata = ref_wdata(n, wd);
      req_q.push_back(rq);
      if (!st) begin
        wv.rd = rd; wv.data = ref_load(n, o, nse, rdata);
        wb_q.push_back(wv);
      end
    end else begin
      mis_exp++;
    end
    exe_mem_op_en_i = 1'b1;
    exe_mem_op_i = st;
    exe_mem_op_size_i = size;
    dec_not_sign_ext_i = nse;
    addr_i = addr;
    wdata_i = wd;
    rd_addr_i = rd;
    glb_stall_i = (k > 0);
    stall_cnt = 0;
    cyc = 0;
    adv = 1'b0;
    while (!adv && cyc < 100) begin
      @(negedge clk);
      if (lsu_stall_o) stall_cnt++;
      adv = !lsu_stall_o && !glb_stall_i;
      @(posedge clk); #1;
      cyc++;
      glb_stall_i = (cyc < k);
    end
    if (!adv) chk("op_timeout", 32'd1, 32'd0);
    chk("stall_cycles", stall_cnt, legal ? (3 + g + r) : 0);
    exe_mem_op_en_i = 1'b0;
    glb_stall_i = 1'b0;
  endtask

  initial begin
    req_t rq;
    rst_ni = 1'b0;
    glb_stall_i = 1'b0;
    exe_mem_op_en_i = 1'b1;
    exe_mem_op_i = 1'b0;
    exe_mem_op_size_i = 2'b10;
    dec_not_sign_ext_i = 1'b0;
    addr_i = 32'h100;
    wdata_i = 32'h0;
    rd_addr_i = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_misaligned", {31'd0, lsu_misaligned_o}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    exe_mem_op_en_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(2'b10, 1'b0, 1'b0, 32'h100, 32'h0, 5'd1, 0, 0, 0, 32'hDEADBEEF);
    run_op(2'b00, 1'b0, 1'b0, 32'h103, 32'h0, 5'd2, 0, 0, 0, 32'h80FF0000);
    run_op(2'b00, 1'b0, 1'b1, 32'h103, 32'h0, 5'd3, 0, 0, 0, 32'h80FF0000);
    run_op(2'b01, 1'b1, 1'b0, 32'h22, 32'h1234ABCD, 5'd0, 3, 0, 0, 32'h0);
    run_op(2'b10, 1'b0, 1'b0, 32'h102, 32'h0, 5'd4, 0, 0, 0, 32'h0);
    run_op(2'b10, 1'b0, 1'b0, 32'h200, 32'h0, 5'd5, 0, 1, 0, 32'hCAFEF00D);
    run_op(2'b00, 1'b1, 1'b0, 32'h201, 32'h000000A5, 5'd0, 0, 0, 1, 32'h0);
    chk("misaligned_pulses_directed", mis_seen, mis_exp);

    // Reset while waiting for rvalid, then a stray rvalid in IDLE
    rsp_auto = 1'b0;
    rq.addr = 32'h100; rq.we = 1'b0; rq.be = 4'hF; rq.wdata = 32'h0;
    req_q.push_back(rq);
    exe_mem_op_en_i = 1'b1; exe_mem_op_i = 1'b0; exe_mem_op_size_i = 2'b10;
    addr_i = 32'h100; rd_addr_i = 5'd7;
    @(posedge clk); #1;
    exe_mem_op_en_i = 1'b0;
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_stall", {31'd0, lsu_stall_o}, 32'd0);
    chk("midrst_req", {31'd0, data_req_o}, 32'd0);
    chk("midrst_addr", data_addr_o, 32'd0);
    chk("midrst_be", {28'd0, data_be_o}, 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_rvalid_wb", {31'd0, wb_valid_o}, 32'd0);
      chk("stray_rvalid_req", {31'd0, data_req_o}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_auto = 1'b1;

    // Random traffic with bubbles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        addr_i = $urandom;
        @(posedge clk); #1;
      end
      run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom & 32'h0000_0FFF, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("misaligned_pulses", mis_seen, mis_exp);
    chk("req_queue_drained", req_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
